// File: rtl/arm_decode_pkg.sv
// arm_decode_pkg: family codes, condition codes and capture FSM states shared by instr_decode
package arm_decode_pkg;
  typedef enum logic [3:0] {
    FAM_DP   = 4'd0,
    FAM_MUL  = 4'd3,
    FAM_MULL = 4'd4,
    FAM_LS   = 4'd8,
    FAM_SWP  = 4'd12,
    FAM_BR   = 4'd14,
    FAM_UND  = 4'd15
  } fam_e;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;
  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_VALID
  } state_e;
endpackage

// File: rtl/instr_decode_if.sv
// instr_decode_if: sequencer/memory side (master) and decoder side (slave) of instr_decode
interface instr_decode_if;
  logic        ld_ir;
  logic        MEM_R;
  logic [31:0] mem_data;
  logic        flags_we;
  logic [3:0]  alu_flags;
  logic [31:0] IR;
  logic        ir_valid;
  logic [3:0]  nzcv;
  logic [3:0]  family_number;
  logic        COND;
  logic        ST;
  logic        PL;
  logic        A;
  logic        IR_20;
  modport master (
    output ld_ir, MEM_R, mem_data, flags_we, alu_flags,
    input  IR, ir_valid, nzcv, family_number, COND, ST, PL, A, IR_20
  );
  modport slave (
    input  ld_ir, MEM_R, mem_data, flags_we, alu_flags,
    output IR, ir_valid, nzcv, family_number, COND, ST, PL, A, IR_20
  );
endinterface

// File: rtl/instr_decode_cond_eval.sv
// cond_eval: ARMv4 condition check of a 4-bit condition field against {N,Z,C,V}
module cond_eval
  import arm_decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      C_EQ: pass = z;
      C_NE: pass = !z;
      C_CS: pass = c;
      C_CC: pass = !c;
      C_MI: pass = n;
      C_PL: pass = !n;
      C_VS: pass = v;
      C_VC: pass = !v;
      C_HI: pass = c && !z;
      C_LS: pass = !c || z;
      C_GE: pass = n == v;
      C_LT: pass = n != v;
      C_GT: pass = !z && (n == v);
      C_LE: pass = z || (n != v);
      C_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/instr_decode.sv
// instr_decode: IR capture FSM, NZCV register and instruction family decode; DECODE_MULL_EN enables multiply-long decode
module instr_decode
  import arm_decode_pkg::*;
(
  input  logic clk,
  input  logic rst,
  instr_decode_if.slave bus
);
  state_e state;
  fam_e   fam;
  logic   st, pl, a;
  logic   take;
  assign take = bus.ld_ir || state == S_WAIT;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_EMPTY;
      bus.IR       <= '0;
      bus.ir_valid <= 1'b0;
      bus.nzcv     <= '0;
    end else begin
      if (bus.flags_we) bus.nzcv <= bus.alu_flags;
      if (take && bus.MEM_R) begin
        bus.IR       <= bus.mem_data;
        state        <= S_VALID;
        bus.ir_valid <= 1'b1;
      end else if (take) begin
        state        <= S_WAIT;
        bus.ir_valid <= 1'b0;
      end
    end
  end
  // first match wins; anything not claimed below is undefined
  always_comb begin
    fam = FAM_UND;
    st  = 1'b0;
    pl  = 1'b0;
    a   = 1'b0;
    if (bus.IR[27:25] == 3'b101) begin
      fam = FAM_BR;
      pl  = bus.IR[24];
    end else if (bus.IR[27:26] == 2'b01) begin
      fam = FAM_LS;
      st  = !bus.IR[20];
      pl  = bus.IR[24];
    end else if (bus.IR[27:23] == 5'b00010 && bus.IR[21:20] == 2'b00 && bus.IR[11:4] == 8'b0000_1001) begin
      fam = FAM_SWP;
    end else if (bus.IR[27:22] == 6'b000000 && bus.IR[7:4] == 4'b1001) begin
      fam = FAM_MUL;
      a   = bus.IR[21];
    end else if (bus.IR[27:23] == 5'b00001 && bus.IR[7:4] == 4'b1001) begin
`ifdef DECODE_MULL_EN
      fam = FAM_MULL;
      a   = bus.IR[21];
`else
      fam = FAM_UND;
`endif
    end else if (bus.IR[27:26] == 2'b00) begin
      fam = FAM_DP;
    end
  end
  assign bus.family_number = fam;
  assign bus.ST            = st;
  assign bus.PL            = pl;
  assign bus.A             = a;
  assign bus.IR_20         = bus.IR[20];
  cond_eval u_cond (
    .cond (bus.IR[31:28]),
    .nzcv (bus.nzcv),
    .pass (bus.COND)
  );
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 The block SHALL have one clock and one reset: clock `clk`, and `rst`, which is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ld_ir  input  1  sequencer request to capture the fetched word.
REQ-005 MEM_R  input  1  memory ready; mem_data valid when high.
REQ-006 mem_data  input  32  fetched instruction word.
REQ-007 flags_we  input  1  write alu_flags into NZCV.
REQ-008 alu_flags  input  4  {N,Z,C,V} from ALU.
REQ-009 IR  output  32  instruction register.
REQ-010 ir_valid  output  1  IR holds a captured instruction.
REQ-011 nzcv  output  4  current flags register.
REQ-012 family_number  output  4  instruction class for the sequencer.
REQ-013 COND  output  1  IR[31:28] condition is satisfied by nzcv.
REQ-014 ST, PL, A, IR_20  output  1 each  decoded control bits.

Function
REQ-015 Capture FSM SHALL have three states, EMPTY, WAIT and VALID, and SHALL enter EMPTY on reset.
REQ-016 When ld_ir=1 and MEM_R=1 in any state, the block SHALL load IR<=mem_data at that edge and go to VALID.
REQ-017 When ld_ir=1 and MEM_R=0, the block SHALL go to WAIT, clear ir_valid and hold IR.
REQ-018 In WAIT, the block SHALL stay until MEM_R=1, then capture mem_data and go to VALID, regardless of ld_ir.
REQ-019 ir_valid SHALL be 1 only in VALID, and SHALL assert the cycle after the capture edge (latency 1).
REQ-020 When flags_we=1, nzcv SHALL load alu_flags at the edge; otherwise nzcv SHALL hold.
REQ-021 If a capture and flags_we occur in the same cycle, both SHALL take effect, and the next-cycle COND SHALL use the new IR and the new flags.
REQ-022 COND, family_number, ST, PL, A and IR_20 SHALL be combinational from IR and nzcv, with no added latency.
REQ-023 COND SHALL implement all ARMv4 codes 0x0-0xE; code 0xF SHALL give COND=0.
REQ-024 Decode priority for IR[27:25]=101 SHALL be family 14 (branch), with PL=IR[24] (link).
REQ-025 Decode priority for IR[27:26]=01 SHALL be family 8 (load/store), with ST=~IR[20] and PL=IR[24].
REQ-026 Decode priority for IR[27:23]=00010, IR[21:20]=00 and IR[11:4]=00001001 SHALL be family 12 (swap).
REQ-027 Decode priority for IR[27:22]=000000 and IR[7:4]=1001 SHALL be family 3 (multiply), with A=IR[21].
REQ-028 Decode priority for IR[27:23]=00001 and IR[7:4]=1001 SHALL be family 4 (multiply long), with A=IR[21].
REQ-029 Any other IR[27:26]=00 SHALL decode as family 0 (data processing); all remaining encodings SHALL decode as family 15 (undefined).
REQ-030 ST, PL and A SHALL be 0 for every family in which they are not defined above; IR_20 SHALL always equal IR[20].

Reset
REQ-031 On rst, the block SHALL set IR=0, nzcv=0, ir_valid=0 and state=EMPTY; rst SHALL override ld_ir and flags_we in the same cycle.
REQ-032 Post-reset decoded outputs SHALL be family_number=0, COND=0 (EQ with Z=0), and ST=PL=A=IR_20=0.
REQ-033 rst asserted in WAIT SHALL abort the pending capture, with no later load.

Configuration
REQ-034 With DECODE_MULL_EN defined, the multiply-long encodings SHALL decode as family 4.
REQ-035 Without DECODE_MULL_EN, those encodings SHALL decode as family 15 with A=0; all other behaviour SHALL be unchanged.

Structure
REQ-036 Family codes (0, 3, 4, 8, 12, 14, 15), condition codes and FSM state encodings SHALL live in shared package arm_decode_pkg.
REQ-037 Condition evaluation SHALL be a sub-module cond_eval, taking IR[31:28] and nzcv and producing COND.

Verification
REQ-038 Reset, then ld_ir=1, MEM_R=1, mem_data=0xE0812003 -> next cycle: ir_valid=1, family 0, COND=1.
REQ-039 Load 0xE0230291 -> family 3, A=1.
REQ-040 Load 0xE5912004 -> family 8, ST=0, PL=1, IR_20=1.
REQ-041 Load 0xE4812004 -> family 8, ST=1, PL=0.
REQ-042 Load 0xEB000010 -> family 14, PL=1.
REQ-043 Load 0x0A000010 with nzcv=0 -> COND=0; then flags_we=1, alu_flags=0100 -> COND=1 the next cycle.
REQ-044 Load 0xE1012092 -> family 12.
REQ-045 Load 0xE0821493 -> family 4 with DECODE_MULL_EN defined, and family 15 without it.
REQ-046 ld_ir=1 with MEM_R=0 for 2 cycles, then MEM_R=1 -> ir_valid stays 0 and IR holds; capture occurs on the MEM_R=1 edge and ir_valid=1 the next cycle; rst asserted during the stall -> IR remains 0.
